// File: rtl/sv_uart_rx_packer_if.sv
// sv_uart_rx_packer_if: AXI-Stream bundle carrying packed receive words
interface sv_uart_rx_packer_if #(
    parameter int DATA_WIDTH = 24
);
    logic [DATA_WIDTH-1:0] tdata;
    logic                  tvalid;
    logic                  tready;
    modport master (output tdata, output tvalid, input tready);
    modport slave  (input tdata, input tvalid, output tready);
endinterface

// File: rtl/sv_uart_rx_packer.sv
// sv_uart_rx_packer: 8N1 receiver packing consecutive bytes MSB-first into AXI-Stream words
module sv_uart_rx_packer #(
    parameter int DATA_WIDTH   = 24,
    parameter int RX_PIPE      = 3,
    parameter int TIMEOUT_BITS = 20
) (
    input  logic                iclk,
    input  logic                irst_n,
    input  logic                irx,
    input  logic [15:0]         idivider,
    sv_uart_rx_packer_if.master m_axis,
    output logic                oframe_err,
    output logic                ooverrun,
    output logic                otimeout,
    output logic                obusy
);
    localparam int WORDS_NUM = DATA_WIDTH / 8;
    localparam int IW        = $clog2(WORDS_NUM);
    localparam int TW        = $clog2(TIMEOUT_BITS + 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t                state;
    logic [RX_PIPE-1:0]    sync;
    logic                  rx_s;
    logic [15:0]           div;
    logic [15:0]           cnt;
    logic [15:0]           pcnt;
    logic [TW-1:0]         tcnt;
    logic [2:0]            bitn;
    logic [7:0]            sh;
    logic [IW-1:0]         idx;
    logic [DATA_WIDTH-1:0] word;
    logic [DATA_WIDTH-1:0] word_next;

    assign rx_s      = sync[RX_PIPE-1];
    assign word_next = {word[DATA_WIDTH-9:0], sh};
    assign obusy     = (state != IDLE) || (idx != '0);

    // metastability guard on the serial line, idles high
    always_ff @(posedge iclk or negedge irst_n) begin
        if (!irst_n) sync <= '1;
        else         sync <= {sync[RX_PIPE-2:0], irx};
    end

    // bit FSM, byte packer, idle timeout and single-entry output register
    always_ff @(posedge iclk or negedge irst_n) begin
        if (!irst_n) begin
            state         <= IDLE;
            div           <= '0;
            cnt           <= '0;
            pcnt          <= '0;
            tcnt          <= '0;
            bitn          <= '0;
            sh            <= '0;
            idx           <= '0;
            word          <= '0;
            m_axis.tdata  <= '0;
            m_axis.tvalid <= 1'b0;
            oframe_err    <= 1'b0;
            ooverrun      <= 1'b0;
            otimeout      <= 1'b0;
        end else begin
            oframe_err <= 1'b0;
            ooverrun   <= 1'b0;
            otimeout   <= 1'b0;
            if (m_axis.tvalid && m_axis.tready) m_axis.tvalid <= 1'b0;
            case (state)
                IDLE: begin
                    if (!rx_s) begin
                        state <= START;
                        cnt   <= 16'd1;
                        div   <= (idivider < 16'd4) ? 16'd4 : idivider;
                        pcnt  <= '0;
                        tcnt  <= '0;
                    end else if (idx != '0) begin
                        if (pcnt == div - 16'd1) begin
                            pcnt <= '0;
                            if (tcnt == TW'(TIMEOUT_BITS - 1)) begin
                                otimeout <= 1'b1;
                                idx      <= '0;
                                tcnt     <= '0;
                            end else begin
                                tcnt <= tcnt + 1'b1;
                            end
                        end else begin
                            pcnt <= pcnt + 16'd1;
                        end
                    end else begin
                        pcnt <= '0;
                        tcnt <= '0;
                    end
                end
                START: begin
                    if (cnt == (div >> 1)) begin
                        state <= rx_s ? IDLE : DATA;
                        cnt   <= 16'd1;
                        bitn  <= '0;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                DATA: begin
                    if (cnt == div) begin
                        sh   <= {rx_s, sh[7:1]};
                        cnt  <= 16'd1;
                        bitn <= bitn + 1'b1;
                        if (bitn == 3'd7) state <= STOP;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                STOP: begin
                    if (cnt == div) begin
                        state <= IDLE;
                        if (!rx_s) begin
                            oframe_err <= 1'b1;
                            idx        <= '0;
                        end else begin
                            word <= word_next;
                            if (idx == IW'(WORDS_NUM - 1)) begin
                                idx <= '0;
                                if (!m_axis.tvalid || m_axis.tready) begin
                                    m_axis.tdata  <= word_next;
                                    m_axis.tvalid <= 1'b1;
                                end else begin
                                    ooverrun <= 1'b1;
                                end
                            end else begin
                                idx <= idx + 1'b1;
                            end
                        end
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_sv_uart_rx_packer.sv
// tb_sv_uart_rx_packer: directed and randomized frames scored against a byte-level packing model
module tb_sv_uart_rx_packer;
    localparam int DW  = 24;
    localparam int TOB = 20;

    logic        iclk     = 1'b0;
    logic        irst_n   = 1'b0;
    logic        irx      = 1'b1;
    logic [15:0] idivider = 16'd16;
    logic        oframe_err, ooverrun, otimeout, obusy;

    sv_uart_rx_packer_if #(.DATA_WIDTH(DW)) m_axis ();

    sv_uart_rx_packer #(.DATA_WIDTH(DW), .RX_PIPE(3), .TIMEOUT_BITS(TOB)) dut (
        .iclk      (iclk),
        .irst_n    (irst_n),
        .irx       (irx),
        .idivider  (idivider),
        .m_axis    (m_axis),
        .oframe_err(oframe_err),
        .ooverrun  (ooverrun),
        .otimeout  (otimeout),
        .obusy     (obusy)
    );

    always #5 iclk = ~iclk;

    int n_checks = 0;
    int n_fail   = 0;
    int n_fe, n_ov, n_to, n_vcyc;
    logic [DW-1:0] got[$];
    logic [DW-1:0] exp_q[$];

    // passive observer: collects handshaken beats and status pulses
    always @(negedge iclk) begin
        if (irst_n) begin
            if (m_axis.tvalid) n_vcyc++;
            if (m_axis.tvalid && m_axis.tready) got.push_back(m_axis.tdata);
            if (oframe_err) n_fe++;
            if (ooverrun) n_ov++;
            if (otimeout) n_to++;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear();
        got.delete();
        n_fe = 0; n_ov = 0; n_to = 0; n_vcyc = 0;
    endtask

    task automatic hold(input logic v, input int n);
        irx = v;
        repeat (n) begin
            @(posedge iclk);
            #1;
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_bit = 1'b1, input int d = 16);
        int e;
        e = (d < 4) ? 4 : d;
        idivider = 16'(d);
        hold(1'b0, e);
        for (int k = 0; k < 8; k++) hold(b[k], e);
        hold(stop_bit, e);
        if (!stop_bit) hold(1'b1, e);
        irx = 1'b1;
    endtask

    function automatic logic [31:0] first_beat();
        return (got.size() > 0) ? 32'(got[0]) : 32'hFFFF_FFFF;
    endfunction

    initial begin
        logic [DW-1:0] mw;
        int            mn, exp_fe;
        m_axis.tready = 1'b1;
        hold(1'b1, 5);
        check("rst_tdata", 32'(m_axis.tdata), 32'h0);
        check("rst_tvalid", 32'(m_axis.tvalid), 32'h0);
        check("rst_flags", {29'h0, oframe_err, ooverrun, otimeout}, 32'h0);
        check("rst_busy", 32'(obusy), 32'h0);
        irst_n = 1'b1;
        hold(1'b1, 4);

        clear();
        send_byte(8'hA5); send_byte(8'h3C); send_byte(8'h0F);
        hold(1'b1, 8);
        check("basic_nbeats", 32'(got.size()), 32'd1);
        check("basic_data", first_beat(), 32'hA53C0F);
        check("basic_vcyc", 32'(n_vcyc), 32'd1);
        check("basic_flags", 32'(n_fe + n_ov + n_to), 32'd0);
        check("basic_busy", 32'(obusy), 32'd0);

        clear();
        m_axis.tready = 1'b0;
        send_byte(8'h11); send_byte(8'h22); send_byte(8'h33);
        check("ovr_hold_valid", 32'(m_axis.tvalid), 32'd1);
        send_byte(8'h44); send_byte(8'h55);
        check("ovr_none_yet", 32'(n_ov), 32'd0);
        send_byte(8'h66);
        hold(1'b1, 3);
        check("ovr_count", 32'(n_ov), 32'd1);
        check("ovr_tdata", 32'(m_axis.tdata), 32'h112233);
        m_axis.tready = 1'b1;
        hold(1'b1, 2);
        check("ovr_drain_n", 32'(got.size()), 32'd1);
        check("ovr_drain_data", first_beat(), 32'h112233);
        check("ovr_valid_low", 32'(m_axis.tvalid), 32'd0);

        clear();
        send_byte(8'h77); send_byte(8'h88, 1'b0);
        send_byte(8'h01); send_byte(8'h02); send_byte(8'h03);
        hold(1'b1, 8);
        check("fe_count", 32'(n_fe), 32'd1);
        check("fe_nbeats", 32'(got.size()), 32'd1);
        check("fe_data", first_beat(), 32'h010203);

        clear();
        hold(1'b0, 5);
        hold(1'b1, 1);
        check("glitch_busy", 32'(obusy), 32'd1);
        hold(1'b1, 30);
        check("glitch_idle", 32'(obusy), 32'd0);
        check("glitch_none", 32'(n_fe + n_ov + n_to + got.size()), 32'd0);

        clear();
        send_byte(8'h5A);
        hold(1'b1, 19 * 16);
        check("to_early", 32'(n_to), 32'd0);
        check("to_busy", 32'(obusy), 32'd1);
        hold(1'b1, 2 * 16);
        check("to_count", 32'(n_to), 32'd1);
        check("to_busy_low", 32'(obusy), 32'd0);
        send_byte(8'hDE); send_byte(8'hAD); send_byte(8'hBE);
        hold(1'b1, 8);
        check("to_nbeats", 32'(got.size()), 32'd1);
        check("to_data", first_beat(), 32'hDEADBE);

        clear();
        m_axis.tready = 1'b0;
        send_byte(8'h10); send_byte(8'h20); send_byte(8'h30);
        send_byte(8'h40);
        hold(1'b0, 16); hold(1'b1, 16); hold(1'b0, 8);
        check("prst_valid", 32'(m_axis.tvalid), 32'd1);
        check("prst_busy", 32'(obusy), 32'd1);
        #2 irst_n = 1'b0;
        #1;
        check("arst_tdata", 32'(m_axis.tdata), 32'h0);
        check("arst_tvalid", 32'(m_axis.tvalid), 32'h0);
        check("arst_busy", 32'(obusy), 32'h0);
        check("arst_flags", {29'h0, oframe_err, ooverrun, otimeout}, 32'h0);
        hold(1'b1, 5);
        irst_n = 1'b1;
        m_axis.tready = 1'b1;
        hold(1'b1, 10);
        clear();
        send_byte(8'h0B); send_byte(8'h0C); send_byte(8'h0D);
        hold(1'b1, 8);
        check("post_rst_n", 32'(got.size()), 32'd1);
        check("post_rst_data", first_beat(), 32'h0B0C0D);

        clear();
        exp_q.delete();
        mw = '0; mn = 0; exp_fe = 0;
        for (int i = 0; i < 30; i++) begin
            logic [7:0] b;
            logic       bad;
            int         d;
            b   = 8'($urandom);
            bad = ($urandom_range(0, 7) == 0);
            d   = $urandom_range(2, 24);
            send_byte(b, !bad, d);
            if (bad) begin
                exp_fe++;
                mn = 0;
            end else begin
                mw = (mw << 8) | DW'(b);
                mn++;
                if (mn == DW / 8) begin
                    exp_q.push_back(mw);
                    mn = 0;
                end
            end
            hold(1'b1, $urandom_range(0, 2 * ((d < 4) ? 4 : d)));
        end
        hold(1'b1, 8);
        check("rnd_nbeats", 32'(got.size()), 32'(exp_q.size()));
        check("rnd_fe", 32'(n_fe), 32'(exp_fe));
        check("rnd_ov_to", 32'(n_ov + n_to), 32'd0);
        for (int i = 0; i < exp_q.size() && i < got.size(); i++)
            check($sformatf("rnd_beat%0d", i), 32'(got[i]), 32'(exp_q[i]));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/sv_uart_rx_packer.md
# sv_uart_rx_packer

Receive-side counterpart of the word-wide UART TX engine. It deserializes 8N1 frames from `irx`, then packs `DATA_WIDTH/8` consecutive bytes into one AXI-Stream word. The first received byte lands in the most-significant byte, matching the transmitter's MSB-byte-first order. It contains its own bit-level receiver (synchronizer, start validation, mid-bit sampling, stop check), an inter-byte timeout, and a single-entry output register with overrun detection.

## Interface
- `DATA_WIDTH`, 24, output word width; multiple of 8, ≥16; `WORDS_NUM = DATA_WIDTH/8`
- `RX_PIPE`, 3, synchronizer depth on `irx`; ≥2
- `TIMEOUT_BITS`, 20, idle bit periods after which a partial word is discarded; ≥1
- `iclk` in 1: the single clock
- `irst_n` in 1: reset, asynchronous, active-low
- `irx` in 1: serial input, idle high
- `idivider` in 16: clock cycles per bit; values <4 treated as 4
- `m_axis_tdata` out DATA_WIDTH: assembled word
- `m_axis_tvalid` out 1: word valid
- `m_axis_tready` in 1: downstream ready
- `oframe_err` out 1: 1-cycle pulse, stop bit sampled 0
- `ooverrun` out 1: 1-cycle pulse, completed word dropped because output register still full
- `otimeout` out 1: 1-cycle pulse, partial word discarded on idle timeout
- `obusy` out 1: FSM not IDLE, or partial word pending

## Operation
- Synchronizer: `irx` passes through `RX_PIPE` flops, all reset to 1. `rx_s` is the last stage.
- `div` is latched from `idivider` (clamped) at start detection. Changes mid-frame are ignored.
- Bit FSM states: IDLE, START, DATA, STOP.
  - IDLE: `rx_s==0` → START. This is detection cycle D; the cycle counter clears.
  - START: at D+floor(div/2), sample `rx_s`. If 0 → DATA. If 1 → IDLE (glitch), with no flag.
  - DATA: every `div` cycles, sample `rx_s` into the shift register, LSB first. After the 8th sample → STOP.
  - STOP: `div` cycles after the last data sample, sample `rx_s`.
    - 1: byte accepted.
    - 0: `oframe_err` pulses; the byte and any partial word are discarded (byte index → 0).
    - Either outcome → IDLE on that same cycle, so a start bit immediately following at mid-stop is caught.
- Packer:
  - On byte accept: `word <= {word[DATA_WIDTH-9:0], byte}` and the byte index increments.
  - When the index reaches `WORDS_NUM-1`, the completed word goes to the output register and the index wraps to 0.
- Output register:
  - Loaded if `!m_axis_tvalid`, or if `m_axis_tvalid && m_axis_tready` in the same cycle. In that case `tvalid` stays 1 with the new data.
  - Otherwise `ooverrun` pulses, the new word is dropped, and the held word and `tvalid` are unchanged.
  - `tvalid` clears on `tvalid && tready` with no new load.
- Timeout:
  - A bit-period prescaler (`div` cycles) and an idle-bit counter run only while FSM is IDLE and byte index ≠ 0.
  - Both clear on any start detection.
  - When the count reaches `TIMEOUT_BITS`: `otimeout` pulses, the index resets to 0, and partial data is discarded.
- Reset (async, any time): FSM → IDLE, index 0, counters 0, synchronizer 1s. All outputs are cleared without waiting for a clock edge.

## Timing
- Reset values: `m_axis_tdata=0`, `m_axis_tvalid=0`, `oframe_err=0`, `ooverrun=0`, `otimeout=0`, `obusy=0`.
- Start edge reaches `rx_s` RX_PIPE cycles after `irx` falls. D is the first cycle `rx_s==0` is seen in IDLE.
- Sample points, relative to D:
  - Start bit: D+floor(div/2).
  - Data bit k (k=0..7): D+floor(div/2)+(k+1)·div.
  - Stop bit: D+floor(div/2)+9·div = cycle S.
- `m_axis_tvalid` (final byte) and all status pulses assert at S+1, i.e. registered, 1 cycle after the deciding sample.
- Timeout pulse fires 1 cycle after the `TIMEOUT_BITS`-th idle bit period completes.
- Simultaneous events:
  - Word completion together with a downstream handshake → load, no overrun.
  - Frame error on the last byte → no word, no overrun.
- `obusy` is combinational from FSM state and byte index.

## Test plan
- `div=16`, `DATA_WIDTH=24`, `tready=1`. Send bytes 0xA5, 0x3C, 0x0F back-to-back → one beat `tdata=0x A53C0F`, `tvalid` high 1 cycle at S+1 of the third byte; no flags.
- `tready=0`. Send words 0x112233 then 0x445566 → `tdata` holds 0x112233; `ooverrun` pulses once at the end of the 6th byte. Then raise `tready` → one handshake and `tvalid` falls.
- Stop bit forced 0 on the 2nd byte of a word → `oframe_err` pulse, no beat. Next bytes 0x01, 0x02, 0x03 → `tdata=0x010203`.
- `irx` low for 5 cycles (`div=16`, less than 8) → FSM returns to IDLE; no flags, no data, `obusy` returns to 0.
- Send 1 byte, then idle 20 bit periods (`TIMEOUT_BITS=20`) → `otimeout` pulse, `obusy` falls. Next 0xDE, 0xAD, 0xBE → `tdata=0xDEADBE`.
- Assert `irst_n` low mid-data-bit of the 2nd byte with `tvalid=1` pending → all outputs 0 immediately. After release, a fresh 3-byte word is received correctly.
